// File: rtl/pos_pkg.sv
// pos_pkg: sequencer state encoding and default timing constants.
package pos_pkg;
    typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;
    localparam int DWELL_CYC_DEF  = 50000000;
    localparam int DEB_CYC_DEF    = 500000;
    localparam int PWM_PERIOD_DEF = 1000000;
    localparam int PWM_BASE_DEF   = 50000;
    localparam int PWM_STEP_DEF   = 49;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability debouncer; rise pulses with the accepted 0->1 edge.
module btn_debounce import pos_pkg::*; #(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYC);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic hit;
    assign hit = cnt == CW'(DEB_CYC - 1);
    // cnt counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) cnt <= '0;
            else if (hit) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pos_sequencer.sv
// pos_sequencer: auto/manual step strobe generator for the position FSM plus servo PWM driver.
module pos_sequencer import pos_pkg::*; #(
    parameter int DWELL_CYC  = DWELL_CYC_DEF,
    parameter int DEB_CYC    = DEB_CYC_DEF,
    parameter int PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int PWM_BASE   = PWM_BASE_DEF,
    parameter int PWM_STEP   = PWM_STEP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       btn_raw,
    input  logic [9:0] i_pos,
    output logic       change,
    output logic       pwm_out,
    output logic       busy,
    output logic [7:0] step_cnt
);
    localparam int DW = $clog2(DWELL_CYC);
    localparam int PW = $clog2(PWM_PERIOD);
    localparam logic [DW-1:0] RELOAD = DW'(DWELL_CYC - 1);
    state_t state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic man, rise, btn_level;
    logic [PW-1:0] pcnt;
    logic [31:0] width, new_w, wsel;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw),
        .level (btn_level),
        .rise  (rise)
    );

    always_comb begin
        state_n = state;
        dwell_n = dwell;
        case (state)
            IDLE: if (start && !stop) begin
                state_n = DWELL;
                dwell_n = RELOAD;
            end
            DWELL: if (stop) state_n = IDLE;
                else if (dwell == '0) state_n = STEP;
                else dwell_n = dwell - 1'b1;
            STEP: begin
                state_n = stop ? IDLE : DWELL;
                dwell_n = RELOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    assign change = (state == STEP) | man;
    assign busy   = state != IDLE;

    // Manual presses only count in IDLE; edges seen while sequencing are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dwell    <= '0;
            man      <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_n;
            dwell    <= dwell_n;
            man      <= rise & btn_level & (state == IDLE);
            step_cnt <= step_cnt + 8'(change);
        end
    end

    // Width is sampled only at frame start so mid-frame i_pos changes cannot glitch the pulse.
    assign new_w = 32'(PWM_BASE) + 32'(i_pos) * 32'(PWM_STEP);
    assign wsel  = (pcnt == '0) ? new_w : width;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt    <= '0;
            width   <= '0;
            pwm_out <= 1'b0;
        end else begin
            pcnt    <= (pcnt == PW'(PWM_PERIOD - 1)) ? '0 : pcnt + 1'b1;
            width   <= wsel;
            pwm_out <= 32'(pcnt) < wsel;
        end
    end
endmodule

// File: tb/tb_pos_sequencer.sv
// tb_pos_sequencer: table-driven control checks plus a strobe scoreboard keyed on cycle number.
module tb_pos_sequencer;
    logic clk = 1'b0, rst, start, stop, btn_raw;
    logic [9:0] i_pos;
    logic change, pwm_out, busy;
    logic [7:0] step_cnt;
    int checks = 0, failures = 0, cyc = 0, exp_cnt = 0;

    typedef struct {int cyc; int cnt;} exp_t;
    typedef struct {logic start; logic stop; logic busy;} vec_t;
    exp_t sb[$];
    vec_t tbl[7];

    pos_sequencer #(
        .DWELL_CYC(4), .DEB_CYC(3), .PWM_PERIOD(20), .PWM_BASE(5), .PWM_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .btn_raw(btn_raw),
        .i_pos(i_pos), .change(change), .pwm_out(pwm_out), .busy(busy), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output bit ok);
        logic p;
        ok = 1'b0;
        p = pwm_out;
        for (int i = 0; i < 60 && !ok; i++) begin
            step(1);
            ok = !p && pwm_out;
            p = pwm_out;
        end
    endtask

    task automatic count_high(input int n, input int sw, input int np, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            hi += int'(pwm_out);
            if (i == sw) i_pos = 10'(np);
            step(1);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && change) begin
            if (sb.size() == 0) chk("unexpected_strobe_cyc", cyc, -1);
            else begin
                e = sb.pop_front();
                chk("strobe_cyc", cyc, e.cyc);
                chk("strobe_cnt", int'(step_cnt), e.cnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int hi, c, k;
        tbl = '{'{0, 0, 0}, '{1, 1, 0}, '{0, 1, 0}, '{1, 0, 1},
                '{1, 0, 1}, '{0, 1, 0}, '{0, 0, 0}};
        rst = 1'b1; start = 1'b0; stop = 1'b0; btn_raw = 1'b0; i_pos = 10'd3;
        step(3);
        chk("rst_change", int'(change), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_step_cnt", int'(step_cnt), 0);
        rst = 1'b0;
        step(1);

        // PWM: width 8, mid-frame change to 10 takes effect next frame (15), saturation
        wait_rise(ok);
        chk("pwm_rise_found", int'(ok), 1);
        count_high(20, 3, 10, hi);
        chk("pwm_high_pos3", hi, 8);
        count_high(20, -1, 10, hi);
        chk("pwm_high_pos10", hi, 15);
        i_pos = 10'd1023;
        step(45);
        count_high(40, -1, 1023, hi);
        chk("pwm_high_pos1023", hi, 40);
        i_pos = 10'd3;

        // start/stop control table: busy one cycle after each applied row
        foreach (tbl[i]) begin
            start = tbl[i].start;
            stop = tbl[i].stop;
            step(1);
            chk($sformatf("tbl_busy_%0d", i), int'(busy), int'(tbl[i].busy));
        end
        start = 1'b0; stop = 1'b0;
        step(5);

        // auto sequencing: strobes 5 cycles apart; a second start must not reload
        c = cyc;
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{c + 5 * (i + 1), exp_cnt + i});
        step(1);
        start = 1'b0;
        chk("auto_busy_rise", int'(busy), 1);
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(14);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("auto_busy_fall", int'(busy), 0);
        exp_cnt += 3;
        chk("auto_step_cnt", int'(step_cnt), exp_cnt);
        step(10);

        // bouncing press in IDLE: one strobe two sync + three stable + one cycle later
        c = cyc;
        btn_raw = 1'b1;
        sb.push_back('{c + 8, exp_cnt});
        exp_cnt++;
        step(1);
        btn_raw = 1'b0;
        step(1);
        btn_raw = 1'b1;
        step(12);
        chk("press_strobe_seen", sb.size(), 0);
        btn_raw = 1'b0;
        step(8);
        chk("press_step_cnt", int'(step_cnt), exp_cnt);

        // same press while busy is discarded
        c = cyc;
        start = 1'b1;
        sb.push_back('{c + 5, exp_cnt});
        sb.push_back('{c + 10, exp_cnt + 1});
        step(1);
        start = 1'b0;
        btn_raw = 1'b1;
        step(1);
        btn_raw = 1'b0;
        step(1);
        btn_raw = 1'b1;
        step(9);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("busy_press_busy", int'(busy), 0);
        exp_cnt += 2;
        step(10);
        btn_raw = 1'b0;
        step(8);
        chk("busy_press_step_cnt", int'(step_cnt), exp_cnt);

        // reset mid-DWELL aborts with no strobe afterwards
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
        chk("mid_rst_change", int'(change), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_step_cnt", int'(step_cnt), 0);
        step(2);
        rst = 1'b0;
        step(15);
        chk("post_rst_busy", int'(busy), 0);
        exp_cnt = 0;

        // 256 strobes wrap step_cnt to 0
        k = 256 - exp_cnt;
        c = cyc;
        start = 1'b1;
        for (int i = 1; i <= k; i++) sb.push_back('{c + 5 * i, (exp_cnt + i - 1) % 256});
        step(1);
        start = 1'b0;
        step(5 * k);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("wrap_step_cnt", int'(step_cnt), 0);
        step(10);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pos_sequencer.md
POS_SEQUENCER -- requirements
Module: pos_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_CYC, default 50000000, giving cycles between automatic steps (min 2).
REQ-002 The block SHALL have parameter DEB_CYC, default 500000, giving cycles a raw button level must be stable to be accepted (min 2).
REQ-003 The block SHALL have parameter PWM_PERIOD, default 1000000, giving the servo frame length in cycles.
REQ-004 The block SHALL have parameter PWM_BASE, default 50000, giving the pulse width in cycles for position 0.
REQ-005 The block SHALL have parameter PWM_STEP, default 49, giving the added pulse cycles per position LSB.
REQ-006 The block SHALL have port clk, input, 1 bit, system clock.
REQ-007 The block SHALL have port rst, input, 1 bit, reset; reset rst, asynchronous, active-high; clock clk.
REQ-008 The block SHALL have port start, input, 1 bit, synchronous request to begin auto sequencing.
REQ-009 The block SHALL have port stop, input, 1 bit, synchronous request to end auto sequencing.
REQ-010 The block SHALL have port btn_raw, input, 1 bit, asynchronous manual-step pushbutton, active-high.
REQ-011 The block SHALL have port i_pos, input, 10 bits, current position code from the position FSM.
REQ-012 The block SHALL have port change, output, 1 bit, single-cycle step strobe to the position FSM.
REQ-013 The block SHALL have port pwm_out, output, 1 bit, servo drive pulse.
REQ-014 The block SHALL have port busy, output, 1 bit, high while auto sequencing.
REQ-015 The block SHALL have port step_cnt, output, 8 bits, count of issued change strobes.

Function
REQ-016 The FSM SHALL have states IDLE, DWELL, STEP.
REQ-017 In IDLE with start=1 and stop=0, the FSM SHALL go to DWELL and load the dwell counter with DWELL_CYC-1.
REQ-018 In DWELL, the counter SHALL decrement once per cycle; at 0 the FSM SHALL go to STEP.
REQ-019 In STEP, change SHALL be 1 for exactly that cycle, after which the FSM SHALL return to DWELL with the counter reloaded, giving one strobe every DWELL_CYC+1 cycles.
REQ-020 stop=1 in DWELL or STEP SHALL force IDLE next cycle; a STEP cycle already in progress SHALL still emit its strobe.
REQ-021 Simultaneous start and stop SHALL be treated as stop.
REQ-022 start while in DWELL or STEP SHALL be ignored, with no counter reload.
REQ-023 busy SHALL be 1 in DWELL and STEP, and 0 in IDLE.
REQ-024 btn_raw SHALL pass through a 2-flop synchronizer, then a debouncer: the accepted level updates only after DEB_CYC consecutive equal samples.
REQ-025 A debounced 0->1 edge in IDLE SHALL produce one change strobe on the following cycle.
REQ-026 Debounced edges outside IDLE SHALL be discarded, not queued.
REQ-027 change SHALL never be high on two consecutive cycles.
REQ-028 step_cnt SHALL increment on every change strobe, wrapping 255->0.
REQ-029 The PWM counter SHALL run freely 0..PWM_PERIOD-1 and wrap.
REQ-030 At count 0, the PWM SHALL latch width = PWM_BASE + i_pos*PWM_STEP, computed unsigned at full width with no truncation.
REQ-031 pwm_out SHALL be 1 while count < latched width; a width >= PWM_PERIOD SHALL give constant 1.
REQ-032 i_pos changes mid-frame SHALL not alter the current pulse (glitch-free).

Reset
REQ-033 While rst=1, the block SHALL hold FSM=IDLE, change=0, busy=0, pwm_out=0, step_cnt=0, all counters 0, latched width 0, synchronizer and debounced level 0.
REQ-034 Reset asserted mid-DWELL or mid-frame SHALL abort immediately, with no strobe on release.
REQ-035 After release, the first PWM frame SHALL latch i_pos at count 0.

Structure
REQ-036 The state encoding (IDLE/DWELL/STEP) and default timing constants SHALL live in shared package pos_pkg.
REQ-037 The synchronizer and debouncer SHALL be sub-module btn_debounce (params DEB_CYC; ports clk, rst, raw, level, rise).
REQ-038 The FSM, dwell counter and PWM SHALL remain in pos_sequencer.

Verification
REQ-039 The bench SHALL use DWELL_CYC=4, DEB_CYC=3, PWM_PERIOD=20, PWM_BASE=5, PWM_STEP=1 in all scenarios.
REQ-040 Scenario: start pulse in IDLE -> busy rises next cycle; change strobes 5 cycles apart; step_cnt 1,2,3.
REQ-041 Scenario: stop during DWELL -> IDLE next cycle, busy=0, no further change; start and stop together from IDLE -> stays IDLE.
REQ-042 Scenario: btn_raw bounces 1-0-1 within 2 cycles, then holds 1 -> exactly one change strobe; same press while busy -> no extra strobe.
REQ-043 Scenario: i_pos=3 -> pwm_out high 8 of 20 cycles; i_pos changed to 10 mid-frame -> next frame high 15 cycles; i_pos=1023 -> constant 1.
REQ-044 Scenario: 256 strobes -> step_cnt wraps to 0; rst mid-DWELL -> all outputs 0, no strobe after release.
